// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative shift-add
// unsigned multiply, with a registered result held under valid/ready backpressure.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  count_q, count_d;

    logic [WIDTH-1:0] sum, diff, alu_res, acc_next;
    logic             alu_ovf, slt, is_mul, accept;

    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign is_mul   = (alu_ctrl == 4'b1000);
    assign slt      = $signed(op_a) < $signed(op_b);
    assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0110: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, slt};
            4'b1100: alu_res = ~(op_a | op_b);
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = StMul;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        overflow_d  = alu_ovf;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CntW'(1);
                if (count_q == LastCnt) begin
                    result_d    = acc_next;
                    zero_d      = (acc_next == '0);
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b1;
                    count_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush abandons any multiply in flight and drops the held result.
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
            count_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: single-cycle ops, iterative MUL,
// backpressure, flush and asynchronous reset.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one single-cycle op with out_ready high and check the registered outputs.
    task automatic single_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res,
                             input logic exp_zero, input logic exp_ovf);
        in_valid  = 1'b1;
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;

        tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        single_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);

        // Back-to-back SUB then SLT, in_ready held high throughout.
        in_valid = 1'b1; alu_ctrl = 4'b0110; op_a = 32'd5; op_b = 32'd5;
        #1;
        check("b2b_ready0", {31'b0, in_ready}, 32'd1);
        tick();
        check("sub_result", result, 32'd0);
        check("sub_zero", {31'b0, zero}, 32'd1);
        check("sub_valid", {31'b0, out_valid}, 32'd1);
        alu_ctrl = 4'b0111; op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001;
        #1;
        check("b2b_ready1", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("slt_result", result, 32'd1);
        check("slt_zero", {31'b0, zero}, 32'd0);
        check("slt_valid", {31'b0, out_valid}, 32'd1);
        tick();
        check("drain_valid", {31'b0, out_valid}, 32'd0);

        single_op("or", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
        single_op("nor", 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        single_op("slt_neg", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);

        // MUL 0x0000FFFF x 0x00010001: busy 32 cycles, result after edge N+32.
        in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = 32'h0000_FFFF; op_b = 32'h0001_0001;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("mul_busy_ready", {31'b0, in_ready}, 32'd0);
            check("mul_busy_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        check("mul1_valid", {31'b0, out_valid}, 32'd1);
        check("mul1_result", result, 32'hFFFF_FFFF);
        check("mul1_ovf", {31'b0, overflow}, 32'd0);

        in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = 32'h8000_0000; op_b = 32'h0000_0002;
        tick();
        in_valid = 1'b0;
        check("mul2_drained", {31'b0, out_valid}, 32'd0);
        repeat (32) tick();
        check("mul2_valid", {31'b0, out_valid}, 32'd1);
        check("mul2_result", result, 32'h0);
        check("mul2_zero", {31'b0, zero}, 32'd1);
        check("mul2_ovf", {31'b0, overflow}, 32'd0);

        // Backpressure: ADD 3+4 held while a second ADD waits on in_valid.
        in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd3; op_b = 32'd4;
        tick();
        out_ready = 1'b0;
        op_a = 32'd1; op_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result", result, 32'd7);
            check("bp_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", {31'b0, out_valid}, 32'd1);
        check("bp_next_result", result, 32'd2);
        tick();
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush during iteration 10 of a MUL, with a transfer offered that must be dropped.
        in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = 32'd3; op_b = 32'd5;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        in_valid = 1'b1; alu_ctrl = 4'b0000; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 25; i++) begin
            tick();
            check("flush_no_result", {31'b0, out_valid}, 32'd0);
        end
        single_op("and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        tick();

        // Asynchronous reset mid-MUL.
        in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = 32'd3; op_b = 32'd5;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_mul_result", result, 32'd0);
        check("arst_mul_valid", {31'b0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_mul_ready", {31'b0, in_ready}, 32'd1);
        repeat (30) tick();
        check("arst_mul_no_result", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset while a result is held under backpressure.
        in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'h7FFF_FFFF; op_b = 32'h1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hold_valid", {31'b0, out_valid}, 32'd0);
        check("arst_hold_result", result, 32'd0);
        check("arst_hold_ovf", {31'b0, overflow}, 32'd0);
        check("arst_hold_zero", {31'b0, zero}, 32'd0);
        #1 rst_n = 1'b1;
        tick();

        single_op("undef", 4'b0101, 32'h0000_FFFF, 32'h0000_1234, 32'h0, 1'b1, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
